poets_stream_mem_reader: RTL

//  Avalon-MM read master paired with the on-chip memory slave. It streams a block of words out as one Avalon-ST packet.
//  It sits between the memory's s1/s2 slave port and the streaming fabric. A control write sets the base and length.
//  It keeps several reads outstanding and uses credit-based flow control into an internal FIFO.

---
 rtl/poets_stream_mem_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/poets_stream_mem_reader.sv
// Avalon-MM burst-less read master that streams a memory block as one
// Avalon-ST packet, with credit-limited outstanding reads into a FWFT FIFO.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   ctl_start/base/len    launch a transfer (base, length sampled on start)
//   ctl_abort             cancel the active transfer
//   ctl_busy/done/aborted status
//   avm_*                 Avalon-MM read master to the memory slave
//   st_*                  Avalon-ST source (readyLatency 0)
module poets_stream_mem_reader #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 13,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ctl_start,
  input  logic [ADDR_W-1:0]   ctl_base,
  input  logic [LEN_W-1:0]    ctl_len,
  input  logic                ctl_abort,
  output logic                ctl_busy,
  output logic                ctl_done,
  output logic                ctl_aborted,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FLUSH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  beat_idx;
  logic [PW-1:0]     pending;
  logic [CW-1:0]     count;
  logic [FW-1:0]     wr_ptr;
  logic [FW-1:0]     rd_ptr;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic              stall_q;
  logic              done_q;
  logic              aborted_q;

  logic              can_issue;
  logic              accept;
  logic              ret;
  logic              active;
  logic              abort_now;
  logic              push;
  logic              pop;
  logic              last_accept;
  logic [CW:0]       credit;

  // Reads in flight plus buffered words may never exceed the FIFO,
  // so every return always has a slot and the slave never stalls.
  assign credit = (CW+1)'(pending) + {1'b0, count};

  assign can_issue = (state == ISSUE)
                   && (issue_left != '0)
                   && (pending < PW'(MAX_PENDING))
                   && (credit < (CW+1)'(FIFO_DEPTH));

  // A read stalled by waitrequest stays asserted until accepted,
  // even if an abort moved the FSM on.
  assign avm_read       = can_issue | stall_q;
  assign avm_address    = addr;
  assign avm_byteenable = '1;

  assign accept      = avm_read & ~avm_waitrequest;
  assign ret         = avm_readdatavalid & (pending != '0);
  assign active      = (state == ISSUE) || (state == DRAIN);
  assign abort_now   = ctl_abort & active;
  assign push        = ret & active & ~ctl_abort;
  assign pop         = st_valid & st_ready;
  assign last_accept = accept && (issue_left == LEN_W'(1));

  assign st_valid = (count != '0);
  assign st_data  = fifo[rd_ptr];
  assign st_sop   = st_valid & (beat_idx == '0);
  assign st_eop   = st_valid & (beat_idx == len_r - LEN_W'(1));

  assign ctl_busy    = (state != IDLE);
  assign ctl_done    = done_q;
  assign ctl_aborted = aborted_q;

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      len_r      <= '0;
      issue_left <= '0;
      beat_idx   <= '0;
      pending    <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      stall_q <= avm_read & avm_waitrequest;
      pending <= pending + PW'(accept) - PW'(ret);

      if (accept) begin
        addr       <= addr + ADDR_W'(1);
        issue_left <= issue_left - LEN_W'(1);
      end

      if (abort_now) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + FW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + FW'(1);
          beat_idx <= beat_idx + LEN_W'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end

      unique case (state)
        IDLE: begin
          if (ctl_start) begin
            aborted_q <= 1'b0;
            if (ctl_len != '0) begin
              state      <= ISSUE;
              addr       <= ctl_base;
              len_r      <= ctl_len;
              issue_left <= ctl_len;
              beat_idx   <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ctl_abort)
            state <= FLUSH;
          else if (last_accept)
            state <= DRAIN;
        end
        DRAIN: begin
          if (ctl_abort) begin
            state <= FLUSH;
          end else if (pop && st_eop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (pending == '0 && count == '0 && !stall_q) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
